// File: rtl/dm_store_buffer.sv
// Load/store front end: FIFO store buffer that drains into the 8-bit data memory port when the core is idle.
// Optional feature macro: DM_SB_FWD_EN enables store-to-load forwarding (loads then only wait on a full buffer).
module dm_store_buffer #(
  parameter int AW       = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_store,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  output logic          req_ready,
  output logic          ld_valid,
  output logic [7:0]    ld_data,
  output logic          sb_empty,
  output logic [AW-1:0] dm_access_addr,
  output logic          dm_read_en,
  output logic          dm_write_en,
  output logic [7:0]    dm_write_val,
  input  logic [7:0]    dm_read_i
);
  localparam int          DATA_W   = 8;
  localparam int          PW       = $clog2(SB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SB_DEPTH);

  logic [AW-1:0]     sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              ld_accept;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full     = (count == FULL_CNT);
  assign sb_empty = (count == '0);

`ifdef DM_SB_FWD_EN
  assign req_ready = !full;

  // Scan oldest to youngest so the last match wins, giving the youngest store's data.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (sb_addr[idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end
`else
  assign req_ready = req_store ? !full : sb_empty;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
`endif

  assign accept    = req_valid && req_ready;
  assign push      = accept && req_store;
  assign ld_accept = accept && !req_store;
  // Drain only when no request is accepted, so read and write never share a cycle.
  assign pop       = !accept && !sb_empty;

  always_comb begin
    dm_access_addr = '0;
    dm_read_en     = 1'b0;
    dm_write_en    = 1'b0;
    dm_write_val   = '0;
    if (ld_accept && !fwd_hit) begin
      dm_read_en     = 1'b1;
      dm_access_addr = req_addr;
    end else if (pop) begin
      dm_write_en    = 1'b1;
      dm_access_addr = sb_addr[head];
      dm_write_val   = sb_data[head];
    end
  end

  // Stage boundary: buffer control and load result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      ld_valid <= ld_accept;
      if (ld_accept) ld_data <= fwd_hit ? fwd_data : dm_read_i;
      if (push) begin
        tail  <= tail + PW'(1);
        count <= count + (PW+1)'(1);
      end else if (pop) begin
        head  <= head + PW'(1);
        count <= count - (PW+1)'(1);
      end
    end
  end

  // Entry payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= req_addr;
      sb_data[tail] <= req_wdata;
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Randomized bench for dm_store_buffer against a queue/array model of the store buffer and memory.
// Directed sequences pin the model with literal expectations; mode follows DM_SB_FWD_EN.
module tb_dm_store_buffer;
  localparam int SB_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_store;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, ld_valid, sb_empty, dm_read_en, dm_write_en;
  logic [7:0] ld_data, dm_access_addr, dm_write_val, dm_read_i;

  dm_store_buffer #(.AW(8), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .sb_empty(sb_empty),
    .dm_access_addr(dm_access_addr), .dm_read_en(dm_read_en),
    .dm_write_en(dm_write_en), .dm_write_val(dm_write_val), .dm_read_i(dm_read_i)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT port.
  bit [7:0]   mem [256];
  logic       pre_en;
  logic [7:0] pre_a, pre_v;
  assign dm_read_i = dm_read_en ? mem[dm_access_addr] : 8'h00;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_v;
    else if (dm_write_en) mem[dm_access_addr] <= dm_write_val;
  end

  // Reference model state.
  typedef struct {logic [7:0] a; logic [7:0] d;} ent_t;
  ent_t     q[$];
  bit [7:0] model_mem [256];
  logic     m_ld_valid;
  logic [7:0] m_ld_data;

  int checks = 0;
  int failures = 0;

  // Values sampled mid-cycle by the most recent step, for literal checks.
  logic       s_ready, s_ren, s_wen, s_empty, s_ldv;
  logic [7:0] s_addr, s_val, s_ldd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    s_ready = req_ready; s_ren = dm_read_en; s_wen = dm_write_en; s_empty = sb_empty;
    s_ldv = ld_valid; s_ldd = ld_data; s_addr = dm_access_addr; s_val = dm_write_val;
  endtask

  // One clock cycle: drive, compare every output to the model, then advance the model.
  task automatic step(input logic v, input logic st, input logic [7:0] a, input logic [7:0] d);
    logic e_ready, e_ren, e_wen, acc, hit;
    logic [7:0] e_addr, e_val, nxt_ld;
    @(negedge clk);
    req_valid = v; req_store = st; req_addr = a; req_wdata = d;
    #1;
    sample();
`ifdef DM_SB_FWD_EN
    e_ready = (q.size() < SB_DEPTH);
`else
    e_ready = st ? (q.size() < SB_DEPTH) : (q.size() == 0);
`endif
    acc = v && e_ready;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = 8'h00; e_val = 8'h00; hit = 1'b0; nxt_ld = m_ld_data;
    if (acc && !st) begin
`ifdef DM_SB_FWD_EN
      for (int i = q.size() - 1; i >= 0; i--)
        if (!hit && q[i].a == a) begin hit = 1'b1; nxt_ld = q[i].d; end
`endif
      if (!hit) begin e_ren = 1'b1; e_addr = a; nxt_ld = model_mem[a]; end
    end else if (!acc && q.size() != 0) begin
      e_wen = 1'b1; e_addr = q[0].a; e_val = q[0].d;
    end
    chk("req_ready", 16'(s_ready), 16'(e_ready));
    chk("sb_empty", 16'(s_empty), 16'(q.size() == 0));
    chk("dm_read_en", 16'(s_ren), 16'(e_ren));
    chk("dm_write_en", 16'(s_wen), 16'(e_wen));
    chk("dm_access_addr", 16'(s_addr), 16'(e_addr));
    chk("dm_write_val", 16'(s_val), 16'(e_val));
    chk("ld_valid", 16'(s_ldv), 16'(m_ld_valid));
    chk("ld_data", 16'(s_ldd), 16'(m_ld_data));
    @(posedge clk);
    if (e_wen) begin model_mem[q[0].a] = q[0].d; q.delete(0); end
    if (acc && st) q.push_back('{a: a, d: d});
    m_ld_valid = acc && !st;
    m_ld_data  = nxt_ld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    #1;
    q.delete(); m_ld_valid = 1'b0; m_ld_data = 8'h00;
    chk("rst_sb_empty", 16'(sb_empty), 16'd1);
    chk("rst_ld_valid", 16'(ld_valid), 16'd0);
    chk("rst_ld_data", 16'(ld_data), 16'h00);
    chk("rst_req_ready", 16'(req_ready), 16'd1);
    chk("rst_dm", {dm_access_addr, dm_write_val}, 16'h0000);
    chk("rst_dm_en", 16'({dm_read_en, dm_write_en}), 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < SB_DEPTH + 2; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    req_valid = 1'b0; pre_en = 1'b1; pre_a = a; pre_v = v;
    @(posedge clk);
    model_mem[a] = v;
    m_ld_valid = 1'b0;
    #1 pre_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    pre_en = 1'b0; pre_a = 8'h00; pre_v = 8'h00;
    m_ld_valid = 1'b0; m_ld_data = 8'h00;
    do_reset();

    // Single store then drain, then read it back.
    step(1'b1, 1'b1, 8'h10, 8'hA5);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("drain_wen", 16'(s_wen), 16'd1);
    chk("drain_addr", 16'(s_addr), 16'h10);
    chk("drain_val", 16'(s_val), 16'hA5);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("after_drain_empty", 16'(s_empty), 16'd1);
    step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("load_back_valid", 16'(s_ldv), 16'd1);
    chk("load_back_data", 16'(s_ldd), 16'hA5);

    // Fill the buffer with back-to-back stores; the fifth waits one drain.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h20 + i), 8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'h24, 8'hC4);
    chk("full_ready", 16'(s_ready), 16'd0);
    chk("full_drain_addr", 16'(s_addr), 16'h20);
    chk("full_drain_wen", 16'(s_wen), 16'd1);
    step(1'b1, 1'b1, 8'h24, 8'hC4);
    chk("refill_ready", 16'(s_ready), 16'd1);
    drain_all();
    for (int i = 0; i < 5; i++) chk("fill_mem", 16'(mem[8'h20 + i]), 16'(8'hC0 + i));

`ifdef DM_SB_FWD_EN
    step(1'b1, 1'b1, 8'h30, 8'h11);
    step(1'b1, 1'b1, 8'h30, 8'h22);
    step(1'b1, 1'b0, 8'h30, 8'h00);
    chk("fwd_ren_accept", 16'(s_ren), 16'd0);
    chk("fwd_ready", 16'(s_ready), 16'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("fwd_ren_next", 16'(s_ren), 16'd0);
    chk("fwd_ld_valid", 16'(s_ldv), 16'd1);
    chk("fwd_ld_data", 16'(s_ldd), 16'h22);
`else
    step(1'b1, 1'b1, 8'h40, 8'h7E);
    step(1'b1, 1'b0, 8'h40, 8'h00);
    chk("nofwd_stall_ready", 16'(s_ready), 16'd0);
    chk("nofwd_stall_drain", 16'(s_wen), 16'd1);
    step(1'b1, 1'b0, 8'h40, 8'h00);
    chk("nofwd_accept_ready", 16'(s_ready), 16'd1);
    chk("nofwd_read_en", 16'(s_ren), 16'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("nofwd_ld_data", 16'(s_ldd), 16'h7E);
`endif
    drain_all();

    // Reset discards a buffered store before it drains.
    preload(8'h50, 8'h33);
    step(1'b1, 1'b1, 8'h50, 8'h99);
    do_reset();
    step(1'b1, 1'b0, 8'h50, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("rst_discard_ld", 16'(s_ldd), 16'h33);
    chk("rst_discard_mem", 16'(mem[8'h50]), 16'h33);

    // Randomized traffic over a narrow address window to exercise forwarding and stalls.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                8'(8'h60 + $urandom_range(0, 7)), 8'($urandom));
    end
    drain_all();
    for (int i = 0; i < 256; i++) chk("final_mem", 16'(mem[i]), 16'(model_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Load/store front end sitting directly upstream of the 8-bit data memory. Accepts one load or store request per cycle from the core, queues stores in a small FIFO store buffer, and drains them into the memory write port in cycles the core leaves idle. Loads read memory combinationally through the same port, or take data forwarded from the buffer. Returns registered load data one cycle after acceptance.

## Interface
Parameters:
- AW, 8, data memory address width; matches the memory's address width.
- SB_DEPTH, 4, store buffer entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  core presents a request.
- req_store  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address.
- req_wdata  in  8  store data.
- req_ready  out  1  combinational; request accepted when req_valid && req_ready.
- ld_valid  out  1  one-cycle pulse; ld_data is new this cycle.
- ld_data  out  8  registered load result; held until the next load completes.
- sb_empty  out  1  store buffer holds no entries.
- dm_access_addr  out  AW  memory address.
- dm_read_en  out  1  memory read strobe.
- dm_write_en  out  1  memory write strobe.
- dm_write_val  out  8  memory write data.
- dm_read_i  in  8  memory read data; valid only while dm_read_en = 1, Z otherwise, ignored then.

## Operation
- Store buffer: circular FIFO of {addr, data}, head and tail pointers of log2(SB_DEPTH) bits with wrap-around, count of log2(SB_DEPTH)+1 bits. full = (count == SB_DEPTH).
- req_ready: store → !full. Load → !full (with forwarding); sb_empty (without forwarding).
- Accepted store: enqueues at tail on the posedge. No memory access in that cycle.
- Accepted load, with forwarding:
  - Youngest buffered entry with matching addr supplies the data; dm_read_en stays 0.
  - No match: dm_read_en = 1, dm_access_addr = req_addr, dm_read_i captured into ld_data.
- Drain: when !sb_empty and no request is accepted this cycle, drive dm_write_en = 1, dm_access_addr = head addr, dm_write_val = head data. Pop head on the posedge.
  - The load stall case (not ready) therefore drains.
  - A full buffer blocks all requests and drains one entry per cycle.
- A forwarded load does not use the port. Drain is still suppressed that cycle; the rule is uniform.
- Port idle (no load read, no drain): all dm_* outputs 0.
- dm_read_en and dm_write_en are never both 1.
- Count update: +1 on push, −1 on pop. Push and pop are mutually exclusive by construction.

## Timing
- Reset values: ld_valid 0, ld_data 8'h00, sb_empty 1, head/tail/count 0, req_ready 1. All dm_* outputs 0.
- Reset mid-operation: buffered stores are discarded, never written; in-flight ld_valid is cleared.
- Load latency: accept in cycle N → ld_valid = 1 and ld_data valid in cycle N+1.
- Store visibility: to a later load immediately via forwarding; in memory one cycle after its drain cycle.
- Drain throughput: one entry per idle cycle. SB_DEPTH back-to-back stores fill the buffer. The next store waits exactly one cycle (one drain), then is accepted.
- dm_* outputs and req_ready are combinational from state and req_*. ld_data, ld_valid and buffer state are registered.

## Configuration
- DM_SB_FWD_EN defined: store-to-load forwarding as above; loads accepted whenever the buffer is not full.
- DM_SB_FWD_EN undefined:
  - No address-match logic.
  - Loads are accepted only when sb_empty = 1; a pending load stalls while the buffer drains.
  - Every load reads memory (dm_read_en = 1).

## Test plan
- Reset with req_valid = 0 → sb_empty = 1, ld_valid = 0, ld_data = 0x00, req_ready = 1, all dm_* 0.
- Store (0x10, 0xA5), then idle → next cycle dm_write_en = 1, addr 0x10, val 0xA5. The following cycle sb_empty = 1; a load of 0x10 returns 0xA5.
- SB_DEPTH = 4, stores to 0x20..0x24 back-to-back:
  - After four accepts, count = 4 and req_ready = 0.
  - One drain writes 0x20, then 0x24 is accepted.
  - Memory finally holds all five.
- Forwarding enabled: stores (0x30, 0x11), (0x30, 0x22), then load 0x30 → ld_valid next cycle, ld_data = 0x22, dm_read_en = 0 throughout.
- Forwarding disabled: store (0x40, 0x7E), then load 0x40 held valid:
  - req_ready = 0 for one cycle while 0x40 is drained.
  - Load accepted next cycle, ld_data = 0x7E.
- Memory preloaded 0x50 = 0x33: store (0x50, 0x99), reset asserted before drain → a later load of 0x50 returns 0x33.
